// File: rtl/cus19_crypto_engine.sv
// cus19_crypto_engine: iterative ENC/DEC accelerator, one round per clock,
// valid/ready handshake on both sides.
// Optional per-mode completion counters: define CUS19_CRYPTO_STATS_EN.
module cus19_crypto_engine #(
  parameter int unsigned Data_Width = 8,
  parameter int unsigned Rounds     = 4,
  parameter int unsigned Rot_Amt    = 3
) (
  input  logic                  cus19_clk_in,
  input  logic                  cus19_rst_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [Data_Width-1:0] in_data,
  input  logic [Data_Width-1:0] in_key,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Data_Width-1:0] out_data,
  output logic                  out_mode,
  output logic                  busy
`ifdef CUS19_CRYPTO_STATS_EN
  ,
  output logic [15:0]           enc_count,
  output logic [15:0]           dec_count
`endif
);

  localparam int unsigned CtrW = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [Data_Width-1:0] x_q, key_q, out_data_q;
  logic                  mode_q, out_mode_q;
  logic [CtrW-1:0]       ctr_q;
  logic [Data_Width-1:0] rk, enc_x, dec_x, round_x;
  logic                  last_round;

  // Left rotate: the upper half of {v,v} shifted left is the rotated word.
  function automatic logic [Data_Width-1:0] rotl(input logic [Data_Width-1:0] v,
                                                 input int unsigned s);
    logic [2*Data_Width-1:0] d;
    d = {v, v} << (s % Data_Width);
    return d[2*Data_Width-1 -: Data_Width];
  endfunction

  function automatic logic [Data_Width-1:0] rotr(input logic [Data_Width-1:0] v,
                                                 input int unsigned s);
    return rotl(v, (Data_Width - (s % Data_Width)) % Data_Width);
  endfunction

  // Round key, both round directions and last-round detection.
  always_comb begin
    rk         = rotl(key_q, int'(ctr_q) % Data_Width) ^ Data_Width'(ctr_q);
    enc_x      = rotl(x_q ^ rk, Rot_Amt) + rk;
    dec_x      = rotr(x_q - rk, Rot_Amt) ^ rk;
    round_x    = mode_q ? enc_x : dec_x;
    last_round = mode_q ? (ctr_q == CtrW'(Rounds - 1)) : (ctr_q == '0);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_round) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge cus19_clk_in or negedge cus19_rst_in) begin
    if (!cus19_rst_in) state_q <= IDLE;
    else               state_q <= state_d;
  end

  // Operand latch, round iteration and result capture.
  always_ff @(posedge cus19_clk_in or negedge cus19_rst_in) begin
    if (!cus19_rst_in) begin
      x_q        <= '0;
      key_q      <= '0;
      mode_q     <= 1'b0;
      ctr_q      <= '0;
      out_data_q <= '0;
      out_mode_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          x_q    <= in_data;
          key_q  <= in_key;
          mode_q <= in_mode;
          ctr_q  <= in_mode ? '0 : CtrW'(Rounds - 1);
        end
        RUN: begin
          x_q   <= round_x;
          ctr_q <= mode_q ? ctr_q + 1'b1 : ctr_q - 1'b1;
          if (last_round) begin
            out_data_q <= round_x;
            out_mode_q <= mode_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;

`ifdef CUS19_CRYPTO_STATS_EN
  logic [15:0] enc_cnt_q, dec_cnt_q;
  logic        handshake;

  assign handshake = (state_q == DONE) && out_ready;

  // Saturating completion counters, bumped on the result handshake.
  always_ff @(posedge cus19_clk_in or negedge cus19_rst_in) begin
    if (!cus19_rst_in) begin
      enc_cnt_q <= '0;
      dec_cnt_q <= '0;
    end else if (handshake) begin
      if (out_mode_q && (enc_cnt_q != '1))  enc_cnt_q <= enc_cnt_q + 16'd1;
      if (!out_mode_q && (dec_cnt_q != '1)) dec_cnt_q <= dec_cnt_q + 16'd1;
    end
  end

  assign enc_count = enc_cnt_q;
  assign dec_count = dec_cnt_q;
`endif

endmodule

// File: tb/tb_cus19_crypto_engine.sv
// Directed and round-trip bench for cus19_crypto_engine (8-bit default,
// single-round and 16-bit instances).
module tb_cus19_crypto_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // default instance: Data_Width 8, Rounds 4, Rot_Amt 3
  logic       in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, busy;
  logic [7:0] in_data, in_key, out_data;
  // single-round instance
  logic       r1_in_valid, r1_in_ready, r1_in_mode, r1_out_valid, r1_out_ready, r1_out_mode, r1_busy;
  logic [7:0] r1_in_data, r1_in_key, r1_out_data;
  // 16-bit instance
  logic        w_in_valid, w_in_ready, w_in_mode, w_out_valid, w_out_ready, w_out_mode, w_busy;
  logic [15:0] w_in_data, w_in_key, w_out_data;
`ifdef CUS19_CRYPTO_STATS_EN
  logic [15:0] enc_count, dec_count, r1_enc, r1_dec, w_enc, w_dec;
`endif

  cus19_crypto_engine #(.Data_Width(8), .Rounds(4), .Rot_Amt(3)) u_dut (
    .cus19_clk_in(clk), .cus19_rst_in(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode), .busy(busy)
`ifdef CUS19_CRYPTO_STATS_EN
    , .enc_count(enc_count), .dec_count(dec_count)
`endif
  );

  cus19_crypto_engine #(.Data_Width(8), .Rounds(1), .Rot_Amt(3)) u_dut_r1 (
    .cus19_clk_in(clk), .cus19_rst_in(rst_n),
    .in_valid(r1_in_valid), .in_ready(r1_in_ready), .in_mode(r1_in_mode),
    .in_data(r1_in_data), .in_key(r1_in_key),
    .out_valid(r1_out_valid), .out_ready(r1_out_ready), .out_data(r1_out_data),
    .out_mode(r1_out_mode), .busy(r1_busy)
`ifdef CUS19_CRYPTO_STATS_EN
    , .enc_count(r1_enc), .dec_count(r1_dec)
`endif
  );

  cus19_crypto_engine #(.Data_Width(16), .Rounds(4), .Rot_Amt(3)) u_dut_w16 (
    .cus19_clk_in(clk), .cus19_rst_in(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_mode(w_in_mode),
    .in_data(w_in_data), .in_key(w_in_key),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_mode(w_out_mode), .busy(w_busy)
`ifdef CUS19_CRYPTO_STATS_EN
    , .enc_count(w_enc), .dec_count(w_dec)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for in_ready (bounded), present operands for one accept edge.
  task automatic start_op(input logic m, input logic [7:0] d, input logic [7:0] k);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_mode = m; in_data = d; in_key = k;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
  endtask

  // Count edges after accept until out_valid (bounded).
  task automatic wait_done();
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // One operation with out_ready held high; low = cycles in_ready was low.
  task automatic op_tied(input logic m, input logic [7:0] d, input logic [7:0] k,
                         output logic [7:0] res, output int low);
    res = '0;
    in_valid = 1'b1; in_mode = m; in_data = d; in_key = k;
    @(posedge clk); #1;
    in_valid = 1'b0;
    low = 0;
    while (!in_ready && low < 50) begin
      if (out_valid) res = out_data;
      @(posedge clk); #1; low++;
    end
  endtask

  task automatic op16_tied(input logic m, input logic [15:0] d, input logic [15:0] k,
                           output logic [15:0] res, output int low);
    res = '0;
    w_in_valid = 1'b1; w_in_mode = m; w_in_data = d; w_in_key = k;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    low = 0;
    while (!w_in_ready && low < 50) begin
      if (w_out_valid) res = w_out_data;
      @(posedge clk); #1; low++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  c8, p8, d8, k8;
    logic [15:0] c16, p16, d16, k16;
    int          low;

    rst_n = 1'b0;
    in_valid = 0; in_mode = 0; in_data = '0; in_key = '0; out_ready = 0;
    r1_in_valid = 0; r1_in_mode = 0; r1_in_data = '0; r1_in_key = '0; r1_out_ready = 0;
    w_in_valid = 0; w_in_mode = 0; w_in_data = '0; w_in_key = '0; w_out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, out_data},  32'd0);
    check("rst_out_mode",  {31'd0, out_mode},  32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single round: ENC 0x0A/0x05 -> 0x7D, valid one edge after accept
    r1_in_valid = 1; r1_in_mode = 1; r1_in_data = 8'h0A; r1_in_key = 8'h05;
    @(posedge clk); #1;
    r1_in_valid = 0;
    lat = 0;
    while (!r1_out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check("r1_lat",  lat, 32'd1);
    check("r1_data", {24'd0, r1_out_data}, 32'h7D);
    check("r1_mode", {31'd0, r1_out_mode}, 32'd1);
    r1_out_ready = 1;
    @(posedge clk); #1;
    r1_out_ready = 0;
    check("r1_ack_valid", {31'd0, r1_out_valid}, 32'd0);

    // default ENC 0x0A/0x05 -> 0xAE, then 10 cycles of backpressure
    start_op(1'b1, 8'h0A, 8'h05);
    wait_done();
    check("enc_lat",  lat, 32'd4);
    check("enc_data", {24'd0, out_data}, 32'hAE);
    check("enc_mode", {31'd0, out_mode}, 32'd1);
    check("enc_busy", {31'd0, busy},     32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid",    {31'd0, out_valid}, 32'd1);
      check("bp_data",     {24'd0, out_data},  32'hAE);
      check("bp_in_ready", {31'd0, in_ready},  32'd0);
    end
    ack();
    check("ack_valid", {31'd0, out_valid}, 32'd0);
    check("ack_ready", {31'd0, in_ready},  32'd1);
    check("ack_busy",  {31'd0, busy},      32'd0);

    // out_ready in IDLE has no effect
    ack();
    check("idle_ack_ready", {31'd0, in_ready},  32'd1);
    check("idle_ack_valid", {31'd0, out_valid}, 32'd0);

    // DEC 0xAE/0x05 -> 0x0A with an in_valid 0xFF pulse during RUN
    start_op(1'b0, 8'hAE, 8'h05);
    in_valid = 1; in_mode = 1; in_data = 8'hFF; in_key = 8'hFF;
    @(posedge clk); #1; lat++;
    @(posedge clk); #1; lat++;
    in_valid = 0;
    wait_done();
    check("dec_lat",      lat, 32'd4);
    check("dec_data",     {24'd0, out_data}, 32'h0A);
    check("dec_mode",     {31'd0, out_mode}, 32'd0);
    check("dec_in_ready", {31'd0, in_ready}, 32'd0);
    ack();

    // ENC 0x00/0x00 -> 0xCD
    start_op(1'b1, 8'h00, 8'h00);
    wait_done();
    check("enc0_data", {24'd0, out_data}, 32'hCD);
    ack();

    // asynchronous reset after two rounds of an ENC
    start_op(1'b1, 8'h0A, 8'h05);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_data",  {24'd0, out_data},  32'd0);
    check("mid_rst_out_mode",  {31'd0, out_mode},  32'd0);
    check("mid_rst_busy",      {31'd0, busy},      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(1'b1, 8'h0A, 8'h05);
    wait_done();
    check("post_rst_lat",  lat, 32'd4);
    check("post_rst_data", {24'd0, out_data}, 32'hAE);
    ack();

    // DEC 0xCD/0x00 -> 0x00
    start_op(1'b0, 8'hCD, 8'h00);
    wait_done();
    check("dec0_data", {24'd0, out_data}, 32'h00);
    ack();

`ifdef CUS19_CRYPTO_STATS_EN
    out_ready = 1'b1;
    op_tied(1'b1, 8'h12, 8'h34, c8, low);
    op_tied(1'b1, 8'h56, 8'h78, c8, low);
    op_tied(1'b0, 8'h9A, 8'hBC, c8, low);
    check("stats_enc", {16'd0, enc_count}, 32'd3);
    check("stats_dec", {16'd0, dec_count}, 32'd2);
    force u_dut.enc_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release u_dut.enc_cnt_q;
    op_tied(1'b1, 8'h01, 8'h02, c8, low);
    check("stats_enc_sat", {16'd0, enc_count}, 32'hFFFF);
    check("stats_dec_kept", {16'd0, dec_count}, 32'd2);
`endif

    // random round trips, out_ready tied high
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      d8 = 8'($urandom); k8 = 8'($urandom);
      op_tied(1'b1, d8, k8, c8, low);
      check("rt8_enc_low", low, 32'd5);
      op_tied(1'b0, c8, k8, p8, low);
      check("rt8_dec_low", low, 32'd5);
      check("rt8_data", {24'd0, p8}, {24'd0, d8});
    end
    out_ready = 1'b0;

    w_out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      d16 = 16'($urandom); k16 = 16'($urandom);
      op16_tied(1'b1, d16, k16, c16, low);
      check("rt16_enc_low", low, 32'd5);
      op16_tied(1'b0, c16, k16, p16, low);
      check("rt16_dec_low", low, 32'd5);
      check("rt16_data", {16'd0, p16}, {16'd0, d16});
    end
    w_out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
